// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI sequencer.
// Frame layout: {cmd[3:0], data[15:0], 4'b0}, shifted MSB first.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  localparam int FRAME_W = 24;

  localparam logic [3:0] CMD_WR_INPUT  = 4'h1;
  localparam logic [3:0] CMD_UPDATE    = 4'h2;
  localparam logic [3:0] CMD_WR_UPDATE = 4'h3;
  localparam logic [3:0] CMD_CTRL      = 4'h4;

  function automatic logic [FRAME_W-1:0] make_frame(
    input logic [3:0]  cmd,
    input logic [15:0] data
  );
    return {cmd, data, 4'b0000};
  endfunction

endpackage

// File: rtl/dac_spi_sequencer_arb.sv
// Two-way round-robin arbiter; last_grant=1 means B won last,
// so A wins the first tie after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~valid[1] | last_q);
    grant[1] = valid[1] & (~valid[0] | ~last_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/dac_spi_sequencer.sv
// Arbitrates two command sources and serialises each granted
// command as a 24-bit frame on the DAC SYNC/SCLK/DIN pins.
module dac_spi_sequencer
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int SYNC_GAP = 4,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a_valid,
  output logic              req_a_ready,
  input  logic [3:0]        req_a_cmd,
  input  logic [DATA_W-1:0] req_a_data,
  input  logic              req_b_valid,
  output logic              req_b_ready,
  input  logic [3:0]        req_b_cmd,
  input  logic [DATA_W-1:0] req_b_data,
  output logic              busy,
  output logic              done,
  output logic              done_src,
  output logic              dac_sync,
  output logic              dac_sclk,
  output logic              dac_din
);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("CLK_DIV must be >= 1");
    end
    if (SYNC_GAP < 1) begin : g_bad_gap
      $error("SYNC_GAP must be >= 1");
    end
    if (DATA_W != 16) begin : g_bad_w
      $error("DATA_W is fixed at 16");
    end
  endgenerate

  localparam int HC_W = $clog2(CLK_DIV + 1);
  localparam int GC_W = $clog2(SYNC_GAP + 1);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(CLK_DIV - 1);
  localparam logic [GC_W-1:0] GC_MAX = GC_W'(SYNC_GAP - 1);
  localparam logic [4:0] BIT_LAST = 5'(FRAME_W - 1);

  state_t state_q, state_d;

  logic [FRAME_W-1:0] sr_q;
  logic [HC_W-1:0]    hc_q;
  logic [GC_W-1:0]    gc_q;
  logic [4:0]         bit_q;
  logic               sclk_q;
  logic               done_q;
  logic               src_q;
  logic               done_src_q;

  logic [1:0]  valid;
  logic [1:0]  grant;
  logic        idle;
  logic        accept;
  logic        half_end;
  logic        last_rise;
  logic        gap_end;
  logic [3:0]  cmd_sel;
  logic [15:0] data_sel;

  assign idle   = (state_q == IDLE);
  assign valid  = {req_b_valid, req_a_valid} & {2{idle}};
  assign accept = |grant;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid  (valid),
    .accept (accept),
    .grant  (grant)
  );

  assign req_a_ready = grant[0];
  assign req_b_ready = grant[1];
  assign cmd_sel     = grant[1] ? req_b_cmd  : req_a_cmd;
  assign data_sel    = grant[1] ? req_b_data : req_a_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    half_end  = 1'b0;
    last_rise = 1'b0;
    gap_end   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        half_end  = (hc_q == HC_MAX);
        // 24th low half ending: sclk rises and the frame closes
        last_rise = half_end & ~sclk_q & (bit_q == BIT_LAST);
        if (last_rise) state_d = GAP;
      end
      GAP: begin
        gap_end = (gc_q == GC_MAX);
        if (gap_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q       <= '0;
      hc_q       <= '0;
      gc_q       <= '0;
      bit_q      <= '0;
      sclk_q     <= 1'b1;
      done_q     <= 1'b0;
      src_q      <= 1'b0;
      done_src_q <= 1'b0;
    end else begin
      done_q <= gap_end;
      if (gap_end) done_src_q <= src_q;
      gc_q <= (state_q == GAP) ? gc_q + 1'b1 : '0;
      if (accept) begin
        sr_q   <= make_frame(cmd_sel, data_sel);
        src_q  <= grant[1];
        hc_q   <= '0;
        bit_q  <= '0;
        sclk_q <= 1'b1;
      end else if (state_q == SHIFT) begin
        hc_q <= half_end ? '0 : hc_q + 1'b1;
        if (half_end) begin
          sclk_q <= ~sclk_q;
          // din advances only on a rising edge
          if (~sclk_q & ~last_rise) begin
            sr_q  <= sr_q << 1;
            bit_q <= bit_q + 1'b1;
          end
        end
      end
    end
  end

  assign busy     = ~idle | done_q;
  assign done     = done_q;
  assign done_src = done_src_q;
  assign dac_sync = (state_q != SHIFT);
  assign dac_sclk = sclk_q;
  assign dac_din  = (state_q == SHIFT) & sr_q[FRAME_W-1];

endmodule

// File: tb/tb_dac_spi_sequencer.sv
// Bench for dac_spi_sequencer: frame vectors, corner sequences
// and a cycle-level reference model under random traffic.
module tb_dac_spi_sequencer;
  import dac_spi_pkg::*;

  localparam int CD0  = 2;
  localparam int CD1  = 1;
  localparam int SG   = 4;
  localparam int LAT0 = 1 + 48 * CD0 + SG;
  localparam int LAT1 = 1 + 48 * CD1 + SG;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a0_v, a0_r, b0_v, b0_r;
  logic [3:0]  a0_c, b0_c;
  logic [15:0] a0_d, b0_d;
  logic        busy0, done0, dsrc0, sync0, sclk0, din0;

  logic        a1_v, a1_r, b1_v, b1_r;
  logic [3:0]  a1_c, b1_c;
  logic [15:0] a1_d, b1_d;
  logic        busy1, done1, dsrc1, sync1, sclk1, din1;

  dac_spi_sequencer #(.CLK_DIV(CD0), .SYNC_GAP(SG), .DATA_W(16)) dut0 (
    .clk(clk), .reset(rst),
    .req_a_valid(a0_v), .req_a_ready(a0_r),
    .req_a_cmd(a0_c), .req_a_data(a0_d),
    .req_b_valid(b0_v), .req_b_ready(b0_r),
    .req_b_cmd(b0_c), .req_b_data(b0_d),
    .busy(busy0), .done(done0), .done_src(dsrc0),
    .dac_sync(sync0), .dac_sclk(sclk0), .dac_din(din0)
  );

  dac_spi_sequencer #(.CLK_DIV(CD1), .SYNC_GAP(SG), .DATA_W(16)) dut1 (
    .clk(clk), .reset(rst),
    .req_a_valid(a1_v), .req_a_ready(a1_r),
    .req_a_cmd(a1_c), .req_a_data(a1_d),
    .req_b_valid(b1_v), .req_b_ready(b1_r),
    .req_b_cmd(b1_c), .req_b_data(b1_d),
    .busy(busy1), .done(done1), .done_src(dsrc1),
    .dac_sync(sync1), .dac_sclk(sclk1), .dac_din(din1)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // reference model state for dut0 (cycle numbers of events)
  int          m_acc  = -1000;
  int          m_done = -1;
  int          m_free = 0;
  bit          m_last = 1'b1;
  bit          m_src  = 1'b0;
  bit          m_dsrc = 1'b0;
  logic [23:0] m_frame = '0;
  bit          chk_en = 1'b0;
  bit          acc_a0 = 1'b0;
  bit          acc_b0 = 1'b0;

  // falling-edge capture of what the DAC would see
  logic        ps0 = 1'b1, pd0 = 1'b0, psy0 = 1'b1;
  logic        ps1 = 1'b1, pd1 = 1'b0, psy1 = 1'b1;
  logic [23:0] cap0 = '0, cap1 = '0;
  int          nb0 = 0, nb1 = 0, low0 = 0, low1 = 0, hi0 = 0;
  logic [23:0] lf0 = '0, lf1 = '0;
  int          lnb0 = 0, lnb1 = 0, llow0 = 0, llow1 = 0;
  int          gapq0[$];
  bit          srcq0[$];

  always @(negedge clk) begin
    bit ea, eb, ins;
    int k;
    ea  = (cyc >= m_free) && a0_v && (!b0_v || m_last);
    eb  = (cyc >= m_free) && b0_v && (!a0_v || !m_last);
    if (cyc == m_done) m_dsrc = m_src;
    k   = cyc - m_acc - 1;
    ins = (k >= 0) && (k < 48 * CD0);
    if (chk_en) begin
      check("ready_a", 32'(a0_r), 32'(ea));
      check("ready_b", 32'(b0_r), 32'(eb));
      check("busy", 32'(busy0), 32'((cyc > m_acc) && (cyc <= m_done)));
      check("done", 32'(done0), 32'(cyc == m_done));
      check("done_src", 32'(dsrc0), 32'(m_dsrc));
      check("sync", 32'(sync0), 32'(!ins));
      check("sclk", 32'(sclk0), 32'(ins ? ((k / CD0) % 2 == 0) : 1'b1));
      check("din", 32'(din0),
            32'(ins ? m_frame[23 - k / (2 * CD0)] : 1'b0));
      if (ps1 && !sclk1 && !sync1)
        check("din1_stable", 32'(din1), 32'(pd1));
    end
    acc_a0 = a0_v & a0_r;
    acc_b0 = b0_v & b0_r;
    if (rst) begin
      m_acc = -1000; m_done = -1; m_free = 0;
      m_last = 1'b1; m_src = 1'b0; m_dsrc = 1'b0;
    end else if (ea || eb) begin
      m_src   = eb;
      m_last  = eb;
      m_frame = make_frame(eb ? b0_c : a0_c, eb ? b0_d : a0_d);
      m_acc   = cyc;
      m_done  = cyc + LAT0;
      m_free  = m_done;
    end

    if (sync0) hi0++;
    else begin
      if (psy0) begin
        gapq0.push_back(hi0);
        nb0 = 0; cap0 = '0; low0 = 0;
      end
      low0++;
      hi0 = 0;
    end
    if (ps0 && !sclk0 && !sync0) begin
      cap0 = {cap0[22:0], din0};
      nb0++;
    end
    if (done0) begin
      lf0 = cap0; lnb0 = nb0; llow0 = low0;
      srcq0.push_back(dsrc0);
    end

    if (!sync1) begin
      if (psy1) begin nb1 = 0; cap1 = '0; low1 = 0; end
      low1++;
    end
    if (ps1 && !sclk1 && !sync1) begin
      cap1 = {cap1[22:0], din1};
      nb1++;
    end
    if (done1) begin lf1 = cap1; lnb1 = nb1; llow1 = low1; end

    ps0 = sclk0; pd0 = din0; psy0 = sync0;
    ps1 = sclk1; pd1 = din1; psy1 = sync1;
  end

  task automatic drive(input int u, input bit b, input bit v,
                       input logic [3:0] c, input logic [15:0] d);
    if (u == 0 && !b) begin a0_v = v; a0_c = c; a0_d = d; end
    if (u == 0 &&  b) begin b0_v = v; b0_c = c; b0_d = d; end
    if (u == 1 && !b) begin a1_v = v; a1_c = c; a1_d = d; end
    if (u == 1 &&  b) begin b1_v = v; b1_c = c; b1_d = d; end
  endtask

  task automatic req(input int u, input bit b, input logic [3:0] c,
                     input logic [15:0] d, output int ac);
    int n;
    bit hs;
    n  = 0;
    ac = -1;
    @(posedge clk); #1;
    drive(u, b, 1'b1, c, d);
    while (ac < 0 && n < 300) begin
      @(negedge clk);
      if (u == 0) hs = b ? (b0_v && b0_r) : (a0_v && a0_r);
      else        hs = b ? (b1_v && b1_r) : (a1_v && a1_r);
      if (hs) ac = cyc;
      n++;
    end
    @(posedge clk); #1;
    drive(u, b, 1'b0, c, d);
    if (ac < 0) check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int u, output int dc, output bit src);
    int n;
    n  = 0;
    dc = -1;
    src = 1'b0;
    while (dc < 0 && n < LAT0 + 60) begin
      @(negedge clk);
      if (u == 0 && done0) begin dc = cyc; src = dsrc0; end
      if (u == 1 && done1) begin dc = cyc; src = dsrc1; end
      n++;
    end
    #1;
    if (dc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // hold both requesters valid until nf frames are accepted
  task automatic both(input int nf, output int got, output bit gq[$]);
    int n;
    int dc;
    bit s;
    got = 0;
    n   = 0;
    gq.delete();
    srcq0.delete();
    gapq0.delete();
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 4'($urandom), 16'($urandom));
    drive(0, 1'b1, 1'b1, 4'($urandom), 16'($urandom));
    while (got < nf && n < nf * (LAT0 + 10)) begin
      @(negedge clk);
      n++;
      if (a0_v && a0_r) begin gq.push_back(1'b0); got++; end
      if (b0_v && b0_r) begin gq.push_back(1'b1); got++; end
      @(posedge clk); #1;
      if (acc_a0) begin a0_c = 4'($urandom); a0_d = 16'($urandom); end
      if (acc_b0) begin b0_c = 4'($urandom); b0_d = 16'($urandom); end
    end
    a0_v = 1'b0;
    b0_v = 1'b0;
    wait_done(0, dc, s);
  endtask

  typedef struct {
    int          u;
    bit          b;
    logic [3:0]  cmd;
    logic [15:0] data;
    logic [23:0] frame;
    int          lat;
    int          low;
  } vec_t;

  vec_t tv[5];

  initial begin
    int ac, dc, got, viol, agr;
    bit s;
    bit gq[$];
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ac, dc, got, viol, agr, nd;
    bit s;
    bit gq[$];

    tv[0] = '{0, 1'b0, CMD_WR_UPDATE, 16'hA5C3, 24'h3A5C30, LAT0, 48*CD0};
    tv[1] = '{0, 1'b1, CMD_WR_INPUT,  16'h1234, 24'h112340, LAT0, 48*CD0};
    tv[2] = '{0, 1'b0, CMD_CTRL,      16'h8001, 24'h480010, LAT0, 48*CD0};
    tv[3] = '{1, 1'b0, CMD_WR_UPDATE, 16'hFFFF, 24'h3FFFF0, LAT1, 48*CD1};
    tv[4] = '{1, 1'b0, CMD_WR_UPDATE, 16'h0000, 24'h300000, LAT1, 48*CD1};

    a0_v = 0; b0_v = 0; a0_c = 0; b0_c = 0; a0_d = 0; b0_d = 0;
    a1_v = 0; b1_v = 0; a1_c = 0; b1_c = 0; a1_d = 0; b1_d = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_sync", 32'(sync0), 32'd1);
    check("rst_sclk", 32'(sclk0), 32'd1);
    check("rst_din", 32'(din0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done_src", 32'(dsrc0), 32'd0);
    check("rst_ready", 32'({a0_r, b0_r, a1_r, b1_r}), 32'd0);
    check("rst_pins1", 32'({sync1, sclk1, din1, busy1, done1}), 32'b11000);

    for (int i = 0; i < 5; i++) begin
      req(tv[i].u, tv[i].b, tv[i].cmd, tv[i].data, ac);
      wait_done(tv[i].u, dc, s);
      check($sformatf("v%0d_latency", i), 32'(dc - ac), 32'(tv[i].lat));
      check($sformatf("v%0d_src", i), 32'(s), 32'(tv[i].b));
      if (tv[i].u == 0) begin
        check($sformatf("v%0d_frame", i), 32'(lf0), 32'(tv[i].frame));
        check($sformatf("v%0d_nbits", i), 32'(lnb0), 32'd24);
        check($sformatf("v%0d_synclow", i), 32'(llow0), 32'(tv[i].low));
      end else begin
        check($sformatf("v%0d_frame", i), 32'(lf1), 32'(tv[i].frame));
        check($sformatf("v%0d_nbits", i), 32'(lnb1), 32'd24);
        check($sformatf("v%0d_synclow", i), 32'(llow1), 32'(tv[i].low));
      end
    end

    // A and B together right after reset: A, then B
    pulse_reset();
    both(2, got, gq);
    check("t2_accepts", 32'(got), 32'd2);
    check("t2_first", 32'(gq.size() > 0 ? gq[0] : 1'b1), 32'd0);
    check("t2_second", 32'(gq.size() > 1 ? gq[1] : 1'b0), 32'd1);
    check("t2_dones", 32'(srcq0.size()), 32'd2);
    check("t2_gap", 32'(gapq0.size() > 1 ? gapq0[1] : 0), 32'(SG + 1));

    // four frames under continuous contention
    both(4, got, gq);
    check("t3_accepts", 32'(got), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      check($sformatf("t3_grant%0d", i), 32'(gq[i]), 32'(i % 2));
    for (int i = 0; i < 4 && i < srcq0.size(); i++)
      check($sformatf("t3_src%0d", i), 32'(srcq0[i]), 32'(i % 2));
    for (int i = 1; i < 4 && i < gapq0.size(); i++)
      check($sformatf("t3_gap%0d", i), 32'(gapq0[i]), 32'(SG + 1));

    // reset in cycle 40 of an A frame
    req(0, 1'b0, CMD_WR_UPDATE, 16'h5A5A, ac);
    while (cyc < ac + 40) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t4_pins", 32'({sync0, sclk0, din0}), 32'b110);
    check("t4_done", 32'(done0), 32'd0);
    check("t4_busy", 32'(busy0), 32'd0);
    nd = 0;
    repeat (LAT0) begin @(negedge clk); if (done0) nd++; end
    check("t4_no_done", 32'(nd), 32'd0);
    req(0, 1'b1, CMD_UPDATE, 16'hBEEF, ac);
    wait_done(0, dc, s);
    check("t4_frame", 32'(lf0), 32'h2BEEF0);
    check("t4_nbits", 32'(lnb0), 32'd24);
    check("t4_src", 32'(s), 32'd1);
    check("t4_latency", 32'(dc - ac), 32'(LAT0));

    // B valid toggling while busy must never see ready
    req(0, 1'b1, CMD_WR_INPUT, 16'h0F0F, ac);
    viol = 0;
    agr  = 0;
    for (int i = 0; i < LAT0 - 10; i++) begin
      @(posedge clk); #1;
      b0_v = (i % 3 == 1);
      @(negedge clk);
      if ((a0_r || b0_r) && busy0 && !done0) viol++;
      if (a0_r) agr++;
    end
    @(posedge clk); #1 b0_v = 1'b0;
    wait_done(0, dc, s);
    check("t6_ready_busy", 32'(viol), 32'd0);
    check("t6_a_grants", 32'(agr), 32'd0);
    check("t6_src", 32'(s), 32'd1);

    // random traffic against the cycle model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      if (acc_a0) a0_v = 1'b0;
      if (acc_b0) b0_v = 1'b0;
      if (!a0_v && $urandom_range(0, 5) == 0) begin
        a0_v = 1'b1; a0_c = 4'($urandom); a0_d = 16'($urandom);
      end
      if (!b0_v && $urandom_range(0, 5) == 0) begin
        b0_v = 1'b1; b0_c = 4'($urandom); b0_d = 16'($urandom);
      end
      if ($urandom_range(0, 799) == 0) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst  = 1'b0;
    a0_v = 1'b0;
    b0_v = 1'b0;
    repeat (LAT0 + 10) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
